// File: rtl/param_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_register
// Purpose  : Multi-mode shift register of DEPTH stages, WIDTH bits each.
//            Supports forward/backward shift, parallel load and optional
//            rotate. It also keeps a saturating fill counter with a full flag.
//            Usable as a serialiser, a deserialiser or a delay line.
// Ports    : clk         - rising-edge clock
//            clear_n     - asynchronous active-low reset
//            sync_clr    - synchronous clear (active-high), beats en/mode
//            en          - clock enable, 0 holds all state
//            mode        - 00 hold, 01 fwd shift, 10 bwd shift, 11 load
//            ser_in_fwd  - enters stage 0 on a forward shift
//            ser_in_bwd  - enters stage DEPTH-1 on a backward shift
//            par_in      - stage i = par_in[i*WIDTH +: WIDTH]
//            par_out     - stage registers, same packing as par_in
//            ser_out_fwd - stage DEPTH-1
//            ser_out_bwd - stage 0
//            fill_count  - number of valid stages (saturates at DEPTH)
//            full        - fill_count == DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module param_shift_register #(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 4,
    parameter int ROTATE = 0
) (
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic                       sync_clr,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           ser_in_fwd,
    input  logic [WIDTH-1:0]           ser_in_bwd,
    input  logic [WIDTH*DEPTH-1:0]     par_in,
    output logic [WIDTH*DEPTH-1:0]     par_out,
    output logic [WIDTH-1:0]           ser_out_fwd,
    output logic [WIDTH-1:0]           ser_out_bwd,
    output logic [$clog2(DEPTH+1)-1:0] fill_count,
    output logic                       full
);

    localparam int              c_CW        = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(DEPTH);
    localparam logic [1:0]      c_MODE_HOLD = 2'b00;
    localparam logic [1:0]      c_MODE_FWD  = 2'b01;
    localparam logic [1:0]      c_MODE_BWD  = 2'b10;
    localparam logic [1:0]      c_MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [c_CW-1:0]  r_fill;

    logic [WIDTH-1:0] w_fwd_in;
    logic [WIDTH-1:0] w_bwd_in;
    logic [c_CW-1:0]  w_fill_inc;

    // In rotate mode the end stage wraps around and serial inputs are ignored.
    assign w_fwd_in   = (ROTATE != 0) ? r_stage[DEPTH-1] : ser_in_fwd;
    assign w_bwd_in   = (ROTATE != 0) ? r_stage[0]       : ser_in_bwd;

    // Saturating increment: the counter never wraps past DEPTH.
    assign w_fill_inc = (r_fill == c_FULL) ? r_fill : r_fill + c_CW'(1);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_fill <= '0;
        end else if (sync_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_fill <= '0;
        end else if (en) begin
            case (mode)
                c_MODE_FWD: begin
                    r_stage[0] <= w_fwd_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                    // Rotation does not bring in new samples, so the count stays.
                    if (ROTATE == 0) begin
                        r_fill <= w_fill_inc;
                    end
                end
                c_MODE_BWD: begin
                    r_stage[DEPTH-1] <= w_bwd_in;
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        r_stage[i] <= r_stage[i+1];
                    end
                    if (ROTATE == 0) begin
                        r_fill <= w_fill_inc;
                    end
                end
                c_MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= par_in[i*WIDTH +: WIDTH];
                    end
                    r_fill <= c_FULL;
                end
                c_MODE_HOLD: begin
                    // All state held.
                end
                default: begin
                    // Unreachable for a 2-bit mode; state held.
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
            assign par_out[gi*WIDTH +: WIDTH] = r_stage[gi];
        end
    endgenerate

    assign ser_out_fwd = r_stage[DEPTH-1];
    assign ser_out_bwd = r_stage[0];
    assign fill_count  = r_fill;
    assign full        = (r_fill == c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_param_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift_register
// Purpose  : Self-checking bench for param_shift_register. It drives three
//            instances with shared control inputs:
//              k=0: W=1 D=4 linear
//              k=1: W=1 D=4 rotate
//              k=2: W=3 D=5 linear
//            A reference model treats each register as one packed number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift_register;

    localparam int KW [3] = '{1, 1, 3};
    localparam int KD [3] = '{4, 4, 5};
    localparam int KR [3] = '{0, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear_n, sync_clr, en;
    logic [1:0]  mode;
    logic        s1f, s1b;
    logic [3:0]  p4;
    logic [2:0]  s3f, s3b;
    logic [14:0] p15;

    logic [3:0]  po0, po1;
    logic        sof0, sob0, sof1, sob1, full0, full1, full2;
    logic [2:0]  fc0, fc1, fc2;
    logic [14:0] po2;
    logic [2:0]  sof2, sob2;

    param_shift_register #(.WIDTH(1), .DEPTH(4), .ROTATE(0)) u_lin (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .en(en), .mode(mode),
        .ser_in_fwd(s1f), .ser_in_bwd(s1b), .par_in(p4), .par_out(po0),
        .ser_out_fwd(sof0), .ser_out_bwd(sob0), .fill_count(fc0), .full(full0));

    param_shift_register #(.WIDTH(1), .DEPTH(4), .ROTATE(1)) u_rot (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .en(en), .mode(mode),
        .ser_in_fwd(s1f), .ser_in_bwd(s1b), .par_in(p4), .par_out(po1),
        .ser_out_fwd(sof1), .ser_out_bwd(sob1), .fill_count(fc1), .full(full1));

    param_shift_register #(.WIDTH(3), .DEPTH(5), .ROTATE(0)) u_wide (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .en(en), .mode(mode),
        .ser_in_fwd(s3f), .ser_in_bwd(s3b), .par_in(p15), .par_out(po2),
        .ser_out_fwd(sof2), .ser_out_bwd(sob2), .fill_count(fc2), .full(full2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mv [3];
    int          mf [3];

    function automatic logic [63:0] msk(input int b);
        return (b >= 64) ? '1 : ((64'd1 << b) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = '0;
            mf[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [63:0] sf, sb, par, top, low;
        int w, d;
        for (int k = 0; k < 3; k++) begin
            w   = KW[k];
            d   = KD[k];
            sf  = (k == 2) ? 64'(s3f) : 64'(s1f);
            sb  = (k == 2) ? 64'(s3b) : 64'(s1b);
            par = (k == 2) ? 64'(p15) : 64'(p4);
            top = (mv[k] >> (w * (d - 1))) & msk(w);
            low = mv[k] & msk(w);
            if (sync_clr) begin
                mv[k] = '0;
                mf[k] = 0;
            end else if (en) begin
                case (mode)
                    2'b01: begin
                        mv[k] = ((mv[k] << w) | ((KR[k] != 0) ? top : sf)) & msk(w * d);
                        if (KR[k] == 0 && mf[k] < d) mf[k]++;
                    end
                    2'b10: begin
                        mv[k] = (mv[k] >> w) | (((KR[k] != 0) ? low : sb) << (w * (d - 1)));
                        if (KR[k] == 0 && mf[k] < d) mf[k]++;
                    end
                    2'b11: begin
                        mv[k] = par & msk(w * d);
                        mf[k] = d;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] po, sof, sob, fc, fl;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin po = 64'(po0); sof = 64'(sof0); sob = 64'(sob0); fc = 64'(fc0); fl = 64'(full0); end
                1:       begin po = 64'(po1); sof = 64'(sof1); sob = 64'(sob1); fc = 64'(fc1); fl = 64'(full1); end
                default: begin po = 64'(po2); sof = 64'(sof2); sob = 64'(sob2); fc = 64'(fc2); fl = 64'(full2); end
            endcase
            chk($sformatf("%s.par_out%0d", tag, k), po, mv[k]);
            chk($sformatf("%s.ser_out_fwd%0d", tag, k), sof, (mv[k] >> (KW[k] * (KD[k] - 1))) & msk(KW[k]));
            chk($sformatf("%s.ser_out_bwd%0d", tag, k), sob, mv[k] & msk(KW[k]));
            chk($sformatf("%s.fill_count%0d", tag, k), fc, 64'(mf[k]));
            chk($sformatf("%s.full%0d", tag, k), fl, 64'(mf[k] == KD[k]));
        end
    endtask

    // One clock edge: inputs already set by the caller, checked 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set(input logic e, input logic sc, input logic [1:0] m);
        en       = e;
        sync_clr = sc;
        mode     = m;
    endtask

    task automatic async_reset(input string tag);
        #2 clear_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".imm_par0"}, 64'(po0), 64'd0);
        #1 clear_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rot_exp [4];
        rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        clear_n = 1'b0; sync_clr = 1'b0; en = 1'b0; mode = 2'b00;
        s1f = 1'b0; s1b = 1'b0; p4 = '0; s3f = '0; s3b = '0; p15 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        clear_n = 1'b1;

        // Forward fill with 1,0,1,1.
        set(1, 0, 2'b01);
        s1f = 1'b1; s3f = 3'd5; tick("t1");
        s1f = 1'b0; s3f = 3'd2; tick("t1");
        s1f = 1'b1; s3f = 3'd7; tick("t1");
        s1f = 1'b1; s3f = 3'd1; tick("t1");
        chk("t1.par_out", 64'(po0), 64'b1011);
        chk("t1.ser_out_fwd", 64'(sof0), 64'd1);
        chk("t1.fill_count", 64'(fc0), 64'd4);
        chk("t1.full", 64'(full0), 64'd1);

        // Five more zero shifts: count saturates, data flushes out.
        s1f = 1'b0; s3f = '0;
        for (int i = 0; i < 5; i++) begin
            tick("t2");
            if (i == 3) chk("t2.flushed", 64'(po0), 64'd0);
        end
        chk("t2.fill_sat", 64'(fc0), 64'd4);

        // Load then three backward shifts.
        set(1, 0, 2'b11); p4 = 4'b1000; p15 = 15'h5A3C; tick("t3");
        set(1, 0, 2'b10); s1b = 1'b0; s3b = 3'd6;
        repeat (3) tick("t3");
        chk("t3.ser_out_bwd", 64'(sob0), 64'd1);
        chk("t3.par_out", 64'(po0), 64'b0001);

        // Rotation on the rotate instance.
        set(1, 0, 2'b11); p4 = 4'b0001; tick("t4");
        set(1, 0, 2'b01); s1f = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("t4");
            chk("t4.rot_par", 64'(po1), 64'(rot_exp[i]));
            chk("t4.rot_fill", 64'(fc1), 64'd4);
        end

        // Sync clear mid-stream with en=0.
        set(1, 1, 2'b00); tick("t5");
        set(1, 0, 2'b01); s1f = 1'b1; s3f = 3'd3;
        repeat (2) tick("t5");
        set(0, 1, 2'b01); tick("t5");
        chk("t5.par_out", 64'(po0), 64'd0);
        chk("t5.fill_count", 64'(fc0), 64'd0);

        // Async reset mid-stream, then en=0 holds; en=0 also holds loaded data.
        set(1, 0, 2'b01); repeat (2) tick("t6");
        async_reset("t6.arst");
        set(0, 0, 2'b01); tick("t6.hold0");
        set(1, 0, 2'b11); p4 = 4'b0110; p15 = 15'h1234; tick("t6");
        set(0, 0, 2'b10); repeat (2) tick("t6.hold");
        set(1, 0, 2'b00); tick("t6.mode_hold");

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            en       = ($urandom_range(0, 7) != 0);
            sync_clr = ($urandom_range(0, 24) == 0);
            mode     = 2'($urandom_range(0, 3));
            s1f      = 1'($urandom);
            s1b      = 1'($urandom);
            p4       = 4'($urandom);
            s3f      = 3'($urandom);
            s3b      = 3'($urandom);
            p15      = 15'($urandom);
            tick("rnd");
            if ($urandom_range(0, 59) == 0) async_reset("rnd.arst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
